// File: rtl/nios_system_led_pwm_pkg.sv
// Shared field layout of the LED control word, blink-select encodings and blink frame limits.
package nios_system_led_pwm_pkg;

  localparam int unsigned MaskLsb  = 0;
  localparam int unsigned MaskW    = 18;
  localparam int unsigned DutyLsb  = 18;
  localparam int unsigned DutyW    = 8;
  localparam int unsigned BlinkLsb = 26;
  localparam int unsigned BlinkW   = 2;

  localparam int unsigned Frames512 = 512;
  localparam int unsigned Frames256 = 256;
  localparam int unsigned Frames128 = 128;
  localparam int unsigned BlinkCntW = 9;

  typedef enum logic [1:0] {
    BlinkNone = 2'b00,
    Blink512  = 2'b01,
    Blink256  = 2'b10,
    Blink128  = 2'b11
  } blink_sel_e;

  // Last frame count before the phase flips for a given select.
  function automatic logic [BlinkCntW-1:0] blink_last(input blink_sel_e sel);
    unique case (sel)
      Blink512: blink_last = BlinkCntW'(Frames512 - 1);
      Blink256: blink_last = BlinkCntW'(Frames256 - 1);
      Blink128: blink_last = BlinkCntW'(Frames128 - 1);
      default:  blink_last = '0;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_led_pwm_if.sv
// LED driver bus: control word in, LED drive and frame strobe out.
interface nios_system_led_pwm_if #(
  parameter int unsigned NUM_LEDS = 18
);
  logic [31:0]         led_word;
  logic [NUM_LEDS-1:0] led_out;
  logic                frame_strobe;

  modport master (output led_word, input led_out, input frame_strobe);
  modport slave  (input led_word, output led_out, output frame_strobe);
endinterface

// File: rtl/nios_system_led_blink_gen.sv
// Blink phase generator: phase flips after a select-dependent number of PWM frames.
module nios_system_led_blink_gen
  import nios_system_led_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_i,
  input  blink_sel_e sel_i,
  output logic       phase_o
);

  blink_sel_e           sel_q, sel_d;
  logic [BlinkCntW-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_i) begin
      sel_d = sel_i;
      // A new select restarts the pattern lit, so the change is visible at once.
      if (sel_i != sel_q) begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (sel_q != BlinkNone) begin
        if (cnt_q == blink_last(sel_q)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + BlinkCntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= BlinkNone;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/nios_system_led_pwm_driver.sv
// Frame-synchronous LED PWM driver with shadowed control word.
// Define NIOS_SYSTEM_LED_BLINK_EN to build the optional blink generator.
module nios_system_led_pwm_driver
  import nios_system_led_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 195,
  parameter int unsigned NUM_LEDS = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_system_led_pwm_if.slave  bus
);

  localparam int unsigned   PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0]      ps_q, ps_d;
  logic [DutyW-1:0]    pwm_q, pwm_d;
  logic [DutyW-1:0]    duty_q, duty_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                strobe_q, strobe_d;
  logic                tick, frame, duty_hit, blink_phase;
  logic [MaskW-1:0]    mask_raw;
  logic                unused_bits;

  assign mask_raw = bus.led_word[MaskLsb +: MaskW];
  assign tick     = (ps_q == PsLast);
  assign frame    = tick && (pwm_q == '1);

`ifdef NIOS_SYSTEM_LED_BLINK_EN
  nios_system_led_blink_gen u_blink_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .frame_i (frame),
    .sel_i   (blink_sel_e'(bus.led_word[BlinkLsb +: BlinkW])),
    .phase_o (blink_phase)
  );
  assign unused_bits = ^{bus.led_word[31:BlinkLsb+BlinkW], mask_raw};
`else
  assign blink_phase = 1'b1;
  assign unused_bits = ^{bus.led_word[31:BlinkLsb], mask_raw};
`endif

  always_comb begin
    ps_d     = tick ? '0 : ps_q + PsW'(1);
    pwm_d    = tick ? pwm_q + DutyW'(1) : pwm_q;
    // Shadow registers only move on the frame boundary, so mid-frame writes never glitch.
    mask_d   = frame ? mask_raw[NUM_LEDS-1:0] : mask_q;
    duty_d   = frame ? bus.led_word[DutyLsb +: DutyW] : duty_q;
    strobe_d = frame;
    duty_hit = (pwm_q < duty_q) || (duty_q == '1);
    led_d    = (duty_hit && blink_phase) ? mask_q : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q     <= '0;
      pwm_q    <= '0;
      duty_q   <= '0;
      mask_q   <= '0;
      led_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      pwm_q    <= pwm_d;
      duty_q   <= duty_d;
      mask_q   <= mask_d;
      led_q    <= led_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.led_out      = led_q;
  assign bus.frame_strobe = strobe_q;

endmodule

// File: doc/nios_system_led_pwm_driver.md
NIOS_SYSTEM_LED_PWM_DRIVER -- requirements
Module: nios_system_led_pwm_driver

Interface
REQ-001 The block SHALL have a parameter PRESCALE, default 195, giving the number of clk cycles per PWM tick (1 kHz PWM frame at 50 MHz).
REQ-002 The block SHALL have a parameter NUM_LEDS, default 18, giving the number of driven LEDs (1..18).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 led_word  input  32  control word from the upstream LED PIO out_port: [17:0] on-mask, [25:18] duty, [27:26] blink select, [31:28] ignored.
REQ-006 led_out  output  NUM_LEDS  physical LED drive, active-high, registered.
REQ-007 frame_strobe  output  1  one-cycle pulse on every PWM frame boundary (shadow load).

Function
REQ-008 The prescaler SHALL count 0..PRESCALE-1 and assert an internal tick in the cycle it equals PRESCALE-1, then wrap to 0.
REQ-009 The 8-bit PWM counter SHALL increment on each tick and wrap 255->0.
REQ-010 A frame boundary SHALL be the cycle in which the tick is asserted with the PWM counter at 255.
REQ-011 On a frame boundary the block SHALL load led_word mask, duty and blink select into shadow registers and pulse frame_strobe for one cycle.
REQ-012 led_word changes between boundaries SHALL have no effect on led_out until the next boundary (glitch-free update).
REQ-013 led_out[i] SHALL be registered as mask[i] AND (pwm_cnt < duty OR duty == 255) AND blink_phase, one clk cycle of latency from the counter state.
REQ-014 Duty 0 SHALL give LEDs that are constantly off, and duty 255 SHALL give LEDs that are constantly on; every other duty value d SHALL give d/256 on-time per frame.
REQ-015 Blink select SHALL map as follows: 00 = no blink (phase held 1); 01 = phase toggles every 512 frames; 10 = every 256 frames; 11 = every 128 frames.
REQ-016 The blink frame counter SHALL advance on each frame boundary and clear to 0 on each phase toggle.
REQ-017 If a loaded blink select differs from the previous shadow value, the blink counter SHALL clear and blink_phase SHALL set to 1 in the same cycle.
REQ-018 Mask bits at index NUM_LEDS and above SHALL be ignored.

Reset
REQ-019 On reset_n low the block SHALL immediately clear the prescaler, PWM counter, shadow registers, blink counter, led_out and frame_strobe to 0, and set blink_phase to 1.
REQ-020 After reset release, the first shadow load SHALL occur at the first frame boundary, and led_out SHALL stay 0 until then.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no residual output pulse.

Configuration
REQ-022 With NIOS_SYSTEM_LED_BLINK_EN defined, the blink function SHALL be as specified in REQ-015 to REQ-017.
REQ-023 Without NIOS_SYSTEM_LED_BLINK_EN, bits [27:26] SHALL be ignored, blink_phase SHALL be constant 1, and no blink counter SHALL be synthesised.

Structure
REQ-024 The package nios_system_led_pwm_pkg SHALL hold the field bit positions and widths of led_word, the blink-select encodings, and the frame-count limits 512/256/128.
REQ-025 Blink phase generation SHALL be one sub-module, nios_system_led_blink_gen, with inputs clk, reset_n, frame boundary and select, and output phase.

Verification
REQ-026 Scenario 1: PRESCALE=1, led_word=0x0200_0001 (mask bit0, duty 128) -> led_out[0] high for exactly 128 of every 256 cycles, frame_strobe every 256 cycles.
REQ-027 Scenario 2: duty 0 and then duty 255 with mask 0x3FFFF -> all LEDs constantly off, then constantly on after the next frame_strobe.
REQ-028 Scenario 3: led_word changed mid-frame from duty 64 to duty 192 -> the current frame keeps 64 on-cycles, and the next frame has 192.
REQ-029 Scenario 4: blink select 11, duty 255, mask bit5 -> led_out[5] toggles every 128 frames; changing the select to 01 restarts with phase 1, then toggles every 512 frames.
REQ-030 Scenario 5: reset_n pulsed low mid-frame with LEDs on -> led_out is 0 asynchronously, and the LEDs stay off until the first frame boundary after release.
REQ-031 Scenario 6: build without NIOS_SYSTEM_LED_BLINK_EN and blink select 10 -> no toggling over 1024 frames.
